// File: rtl/shift_reg_seq.sv
// Sequences an external loadable/shiftable register for MSB-first serial transmission.
// One LOAD cycle, N SHIFT cycles, one DONE cycle; ready only in IDLE, abort cancels and clears.
module shift_reg_seq #(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = $clog2(WIDTH + 1),
  parameter logic FILL_BIT = 1'b0
) (
  input  logic             ck,
  input  logic             rstN,
  input  logic             start,
  output logic             ready,
  input  logic [CNT_W-1:0] nbits,
  input  logic             clear_req,
  input  logic             abort,
  input  logic             q_msb,
  output logic             clr,
  output logic             ld,
  output logic             shl,
  output logic             shIn,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_nbits;

  // Zero or out-of-range requests send the full register width.
  assign w_nbits = ((nbits == '0) || (nbits > CNT_W'(WIDTH))) ? CNT_W'(WIDTH) : nbits;

  always_ff @(posedge ck) begin
    if (!rstN) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    ready      = 1'b0;
    clr        = 1'b0;
    ld         = 1'b0;
    shl        = 1'b0;
    shIn       = 1'b0;
    ser_out    = 1'b0;
    ser_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_next     = LOAD;
          w_cnt_next = w_nbits;
        end else if (clear_req) begin
          w_next = CLEAR;
        end
      end
      LOAD: begin
        busy   = 1'b1;
        ld     = 1'b1;
        w_next = abort ? CLEAR : SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        shl        = 1'b1;
        shIn       = FILL_BIT;
        ser_valid  = 1'b1;
        ser_out    = q_msb;
        w_cnt_next = r_cnt - 1'b1;
        // An abort still counts the bit on the wire this cycle as sent.
        if (abort) begin
          w_next = CLEAR;
        end else if (r_cnt == CNT_W'(1)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = IDLE;
      end
      CLEAR: begin
        busy   = 1'b1;
        clr    = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (!rstN) begin
      ready     = 1'b0;
      clr       = 1'b0;
      ld        = 1'b0;
      shl       = 1'b0;
      shIn      = 1'b0;
      ser_out   = 1'b0;
      ser_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: drives a behavioural 8-bit register from the sequencer controls
// and checks serial streams, timing and register contents against computed expectations.
module tb_shift_reg_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             ck = 1'b0;
  logic             rstN;
  logic             start;
  logic             ready;
  logic [CNT_W-1:0] nbits;
  logic             clear_req;
  logic             abort;
  logic             q_msb;
  logic             clr;
  logic             ld;
  logic             shl;
  logic             shIn;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] d_in = '0;
  logic [WIDTH-1:0] q    = '0;

  int total = 0;
  int bad   = 0;

  // Per-transfer observations
  int         nv, ld_cnt, ld_cyc, done_cnt, done_cyc, clr_cnt, clr_cyc, rdy_cyc, viol;
  logic [7:0] bits;

  always #5 ck = ~ck;

  shift_reg_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W), .FILL_BIT(1'b0)) dut (
    .ck(ck), .rstN(rstN), .start(start), .ready(ready), .nbits(nbits),
    .clear_req(clear_req), .abort(abort), .q_msb(q_msb), .clr(clr), .ld(ld),
    .shl(shl), .shIn(shIn), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .done(done)
  );

  // The controlled register
  always @(posedge ck) begin
    if (clr)      q <= '0;
    else if (ld)  q <= d_in;
    else if (shl) q <= {q[WIDTH-2:0], shIn};
  end
  assign q_msb = q[WIDTH-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && ready !== 1'b1; i++) @(negedge ck);
  endtask

  // Issue one request and observe until ready returns; abort_at=k aborts on the k-th shift cycle.
  task automatic run_xfer(input logic [7:0] d, input logic [3:0] nb, input int abort_at,
                          input logic with_clear);
    @(negedge ck);
    wait_ready();
    d_in = d; nbits = nb; start = 1'b1; clear_req = with_clear;
    nv = 0; ld_cnt = 0; ld_cyc = 0; done_cnt = 0; done_cyc = 0;
    clr_cnt = 0; clr_cyc = 0; rdy_cyc = 0; viol = 0; bits = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge ck);
      start = 1'b0; clear_req = 1'b0; abort = 1'b0;
      if ((32'(ld) + 32'(shl) + 32'(clr)) > 1) viol++;
      if (!ser_valid && ser_out) viol++;
      if (ld) begin ld_cnt++; ld_cyc = cyc; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (clr) begin clr_cnt++; clr_cyc = cyc; end
      if (ser_valid) begin
        nv++;
        bits = {bits[6:0], ser_out};
        if (nv == abort_at) abort = 1'b1;
      end
      if (ready) begin rdy_cyc = cyc; break; end
    end
    abort = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic [3:0] nb;
    int         exp_n;
    logic [7:0] exp_bits;
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vec_t       v;
    int         k, m, ab;
    logic [7:0] rd, rq, rb;
    logic [3:0] rn;
    int         dq[$];

    vecs[0] = '{8'b10110001, 4'd8,  8, 8'b10110001, 8'h00};
    vecs[1] = '{8'b11110001, 4'd3,  3, 8'b00000111, 8'b10001000};
    vecs[2] = '{8'b11110001, 4'd0,  8, 8'b11110001, 8'h00};
    vecs[3] = '{8'h3C,       4'd15, 8, 8'h3C,       8'h00};
    vecs[4] = '{8'hA5,       4'd1,  1, 8'h01,       8'h4A};

    rstN = 1'b0; start = 1'b0; nbits = '0; clear_req = 1'b0; abort = 1'b0;
    repeat (3) @(negedge ck);
    chk("rst_outputs", {23'd0, ready, clr, ld, shl, shIn, ser_out, ser_valid, busy, done}, 32'd0);
    rstN = 1'b1;
    @(negedge ck);
    chk("idle_ready", {30'd0, ready, busy}, 32'b10);

    // Table of plain transfers
    foreach (vecs[i]) begin
      v = vecs[i];
      run_xfer(v.d, v.nb, 0, 1'b0);
      chk($sformatf("v%0d_nbits", i), nv, v.exp_n);
      chk($sformatf("v%0d_bits", i), bits, v.exp_bits);
      chk($sformatf("v%0d_ld", i), {ld_cnt[15:0], ld_cyc[15:0]}, {16'd1, 16'd1});
      chk($sformatf("v%0d_done", i), {done_cnt[15:0], done_cyc[15:0]}, {16'd1, 16'(v.exp_n + 2)});
      chk($sformatf("v%0d_ready", i), rdy_cyc, v.exp_n + 3);
      chk($sformatf("v%0d_q", i), q, v.exp_q);
      chk($sformatf("v%0d_noclr", i), clr_cnt, 0);
      chk($sformatf("v%0d_excl", i), viol, 0);
    end

    // Abort on the third shift cycle
    run_xfer(8'hA5, 4'd8, 3, 1'b0);
    chk("abort_nbits", nv, 3);
    chk("abort_bits", bits, 8'b101);
    chk("abort_clr", {clr_cnt[15:0], clr_cyc[15:0]}, {16'd1, 16'd5});
    chk("abort_nodone", done_cnt, 0);
    chk("abort_ready", rdy_cyc, 6);
    chk("abort_q", q, 8'h00);

    // start and clear_req together: start wins
    run_xfer(8'hFF, 4'd2, 0, 1'b1);
    chk("both_ld", ld_cnt, 1);
    chk("both_noclr", clr_cnt, 0);
    chk("both_q", q, 8'hFC);
    // clear_req alone
    clear_req = 1'b1;
    @(negedge ck);
    clear_req = 1'b0;
    chk("clr_pulse", {29'd0, clr, busy, ready}, 32'b110);
    @(negedge ck);
    chk("clr_after", {29'd0, clr, busy, ready}, 32'b001);
    chk("clr_q", q, 8'h00);

    // Reset in mid-shift
    d_in = 8'hFF; nbits = 4'd8; start = 1'b1;
    @(negedge ck);
    start = 1'b0;
    repeat (3) @(negedge ck);
    chk("mid_in_shift", {30'd0, ser_valid, busy}, 32'b11);
    rstN = 1'b0;
    @(negedge ck);
    chk("mid_rst_outputs", {23'd0, ready, clr, ld, shl, shIn, ser_out, ser_valid, busy, done}, 32'd0);
    rstN = 1'b1;
    @(negedge ck);
    chk("mid_idle", {29'd0, ready, busy, done}, 32'b100);
    run_xfer(8'h3C, 4'd8, 0, 1'b0);
    chk("post_rst_bits", bits, 8'h3C);
    chk("post_rst_done", done_cyc, 10);

    // Held start, back-to-back transfers of 2 bits
    @(negedge ck);
    wait_ready();
    nbits = 4'd2; start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge ck);
      if (done) dq.push_back(c);
    end
    start = 1'b0;
    chk("held_count", dq.size(), 5);
    for (int i = 1; i < dq.size(); i++) chk($sformatf("held_gap%0d", i), dq[i] - dq[i-1], 5);
    if (dq.size() > 0) chk("held_first", dq[0], 4);
    @(negedge ck);
    wait_ready();

    // Randomized transfers against a count-and-shift model
    for (int t = 0; t < 40; t++) begin
      rd = 8'($urandom);
      rn = 4'($urandom_range(0, 15));
      k  = (rn == 0 || rn > 8) ? 8 : int'(rn);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, k)) : 0;
      m  = (ab != 0) ? ab : k;
      rb = rd >> (8 - m);
      rq = (ab != 0) ? 8'h00 : 8'(rd << k);
      run_xfer(rd, rn, ab, 1'b0);
      chk($sformatf("r%0d_nbits", t), nv, m);
      chk($sformatf("r%0d_bits", t), bits, rb);
      chk($sformatf("r%0d_q", t), q, rq);
      chk($sformatf("r%0d_ready", t), rdy_cyc, m + 3);
      chk($sformatf("r%0d_done", t), done_cnt, (ab != 0) ? 0 : 1);
      chk($sformatf("r%0d_clr", t), clr_cnt, (ab != 0) ? 1 : 0);
      chk($sformatf("r%0d_excl", t), viol, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Sequencer for the team's 8-bit loadable/shiftable register with clear and shift-in: drives its clr, ld, shl and shIn controls to perform parallel-to-serial transmission.
- Accepts a transmit request with a valid/ready handshake, loads the register, then shifts out a programmable number of MSB-first bits.
- Presents each bit on ser_out with a strobe, then pulses done.
- Sits between a byte producer (which drives the register's d input) and a serial consumer.

Parameters:
- WIDTH, 8, register width in bits.
- CNT_W, $clog2(WIDTH+1), width of the nbits port and the internal bit counter.
- FILL_BIT, 1'b0, value driven on shIn while shifting.

Ports:
- ck  in  1  clock; all state updates on rising edge.
- rstN  in  1  reset, synchronous, active-low.
- start  in  1  transmit request (valid); may be held.
- ready  out  1  high only in IDLE with rstN=1; the request is accepted on an edge where start=1 and ready=1.
- nbits  in  CNT_W  bits to send; sampled at acceptance; 0 or >WIDTH means WIDTH.
- clear_req  in  1  request a register clear; honoured only in IDLE.
- abort  in  1  cancel an in-progress transfer.
- q_msb  in  1  register output q[WIDTH-1].
- clr  out  1  to register clr.
- ld  out  1  to register ld.
- shl  out  1  to register shl.
- shIn  out  1  to register shIn.
- ser_out  out  1  serial data (equals q_msb while ser_valid=1, else 0).
- ser_valid  out  1  qualifies ser_out, one bit per cycle.
- busy  out  1  high in LOAD, SHIFT, DONE and CLEAR.
- done  out  1  one-cycle pulse when a transfer completes normally.

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, DONE, CLEAR. The state register and bit counter are the only flops. All outputs decode combinationally from state and the q_msb input.
- Reset: on a rising edge with rstN=0, state becomes IDLE and the counter is 0. While rstN=0, ready=0 and every other output is 0. rstN overrides every other input, including mid-transfer.
- IDLE: ready=1, all register controls 0.
  - start=1 → LOAD; the counter loads nbits (clamped as defined above).
  - Else clear_req=1 → CLEAR.
  - start has priority over clear_req. abort is ignored in IDLE.
- LOAD: ld=1 for exactly one cycle; the register captures d at the closing edge. Next state is SHIFT. abort=1 → CLEAR instead.
- SHIFT: shl=1, shIn=FILL_BIT, ser_valid=1, ser_out=q_msb.
  - The counter decrements every edge.
  - When counter==1 at the edge → DONE.
  - abort=1 → CLEAR; the bit present on that cycle counts as emitted.
- DONE: done=1 for one cycle, then IDLE. The register keeps its shifted contents (no clear).
- CLEAR: clr=1 for one cycle, then IDLE. done is not asserted.
- ld, shl and clr are mutually exclusive in every state.
- Timing: acceptance on edge E0 → LOAD in cycle 1 → SHIFT in cycles 2..N+1 → DONE in cycle N+2 → ready=1 again in cycle N+3.
- start held across DONE starts a new transfer on the first IDLE edge; there are no bubble cycles beyond IDLE itself.
- Inputs other than abort and rstN are ignored while busy=1.

Test Plan:
- Reset, then d=8'b10110001, nbits=8, one-cycle start:
  - ld high exactly 1 cycle;
  - ser_out=1,0,1,1,0,0,0,1 on 8 consecutive ser_valid cycles;
  - done pulses in cycle 10; q=8'h00; ready high in cycle 11.
- d=8'b11110001, nbits=3:
  - ser_out=1,1,1;
  - q=8'b10001000 after done;
  - nbits=0 repeat yields 8 bits.
- Transfer of 8'hA5 with abort asserted on the 3rd SHIFT cycle:
  - 3 bits emitted (1,0,1);
  - clr high the next cycle; q=8'h00; no done; ready returns the cycle after.
- start=1 and clear_req=1 together in IDLE: LOAD taken and clr never asserted. clear_req alone: one clr cycle, then q=8'h00.
- rstN driven low for one edge in mid-SHIFT:
  - the next cycle is IDLE with all outputs 0 while rstN=0;
  - no done;
  - a subsequent start with 8'h3C transmits 0,0,1,1,1,1,0,0 correctly.
- start held high continuously with nbits=2: back-to-back transfers, done pulses exactly 5 cycles apart.
